// File: rtl/wb_io_ctrl.sv
// Wishbone register block for debounced push-buttons (sticky rising-edge
// events, level interrupt) and LEDs with optional PWM dimming.
module wb_io_ctrl #(
  parameter int          NUM_BUTTONS = 3,
  parameter int          NUM_LEDS    = 4,
  parameter int          DEBOUNCE_W  = 16,
  parameter int          PWM_W       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  output logic                   o_wb_ack,
  output logic [31:0]            o_wb_data,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [NUM_LEDS-1:0]    led_enb,
  output logic                   irq
);

  localparam logic [5:0] OFF_LED_VAL   = 6'h00;
  localparam logic [5:0] OFF_LED_MODE  = 6'h01;
  localparam logic [5:0] OFF_PWM_DUTY  = 6'h02;
  localparam logic [5:0] OFF_BTN_STATE = 6'h03;
  localparam logic [5:0] OFF_BTN_EVENT = 6'h04;
  localparam logic [5:0] OFF_IRQ_EN    = 6'h05;
  localparam logic [5:0] OFF_DEBOUNCE  = 6'h06;
  localparam logic [5:0] OFF_LED_OEB   = 6'h07;

  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = 1;
  localparam logic [PWM_W-1:0]      PWM_ONE = 1;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Handshake: a request is cyc & stb with a matching address while ack is
  // low. It is answered by exactly one ack cycle on the next edge; that edge
  // also commits a write and registers read data. The master holds the
  // request until it samples ack.
  logic                   r_ack;
  logic [31:0]            r_rdata;
  logic                   w_sel;
  logic                   w_wr;
  logic [5:0]             w_off;
  logic [31:0]            w_rd_data;
  logic                   w_unused;

  logic [NUM_LEDS-1:0]    r_led_val;
  logic [NUM_LEDS-1:0]    r_led_mode;
  logic [PWM_W-1:0]       r_pwm_duty;
  logic [NUM_BUTTONS-1:0] r_btn_event;
  logic [NUM_BUTTONS-1:0] r_irq_en;
  logic [DEBOUNCE_W-1:0]  r_debounce;
  logic [NUM_LEDS-1:0]    r_led_oeb;

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] r_stable;
  logic [DEBOUNCE_W-1:0]  r_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] w_cnt_hit;
  logic [NUM_BUTTONS-1:0] w_stable_nxt;
  logic [NUM_BUTTONS-1:0] w_evt_set;
  logic [NUM_BUTTONS-1:0] w_evt_clr;

  logic [PWM_W-1:0]       r_pwm_cnt;
  logic                   w_pwm;
  logic [NUM_LEDS-1:0]    r_leds;
  logic [NUM_LEDS-1:0]    r_led_enb;
  logic                   r_irq;

  assign w_sel    = i_wb_cyc & i_wb_stb & ~r_ack & (i_wb_addr[31:8] == BASE_ADDR[31:8]);
  assign w_wr     = w_sel & i_wb_we;
  assign w_off    = i_wb_addr[7:2];
  assign w_unused = ^{i_wb_addr[1:0], i_wb_data};

  always_comb begin
    w_rd_data = '0;
    case (w_off)
      OFF_LED_VAL:   w_rd_data[NUM_LEDS-1:0]    = r_led_val;
      OFF_LED_MODE:  w_rd_data[NUM_LEDS-1:0]    = r_led_mode;
      OFF_PWM_DUTY:  w_rd_data[PWM_W-1:0]       = r_pwm_duty;
      OFF_BTN_STATE: w_rd_data[NUM_BUTTONS-1:0] = r_stable;
      OFF_BTN_EVENT: w_rd_data[NUM_BUTTONS-1:0] = r_btn_event;
      OFF_IRQ_EN:    w_rd_data[NUM_BUTTONS-1:0] = r_irq_en;
      OFF_DEBOUNCE:  w_rd_data[DEBOUNCE_W-1:0]  = r_debounce;
      OFF_LED_OEB:   w_rd_data[NUM_LEDS-1:0]    = r_led_oeb;
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_sel;
      r_rdata <= (w_sel & ~i_wb_we) ? w_rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_led_val  <= '0;
      r_led_mode <= '0;
      r_pwm_duty <= '0;
      r_irq_en   <= '0;
      r_debounce <= '1;
      r_led_oeb  <= '1;
    end else if (w_wr) begin
      case (w_off)
        OFF_LED_VAL:  r_led_val  <= i_wb_data[NUM_LEDS-1:0];
        OFF_LED_MODE: r_led_mode <= i_wb_data[NUM_LEDS-1:0];
        OFF_PWM_DUTY: r_pwm_duty <= i_wb_data[PWM_W-1:0];
        OFF_IRQ_EN:   r_irq_en   <= i_wb_data[NUM_BUTTONS-1:0];
        OFF_DEBOUNCE: r_debounce <= i_wb_data[DEBOUNCE_W-1:0];
        OFF_LED_OEB:  r_led_oeb  <= i_wb_data[NUM_LEDS-1:0];
        default: ;
      endcase
    end
  end

  // A button's stable level follows the synchronised level only after it has
  // differed for DEBOUNCE+1 consecutive cycles; DEBOUNCE=0 means no filtering.
  always_comb begin
    w_cnt_hit    = '0;
    w_stable_nxt = r_stable;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_cnt_hit[i] = (r_cnt[i] == r_debounce);
      if ((r_sync2[i] != r_stable[i]) && w_cnt_hit[i]) w_stable_nxt[i] = r_sync2[i];
    end
  end

  assign w_evt_set = w_stable_nxt & ~r_stable;
  assign w_evt_clr = (w_wr && (w_off == OFF_BTN_EVENT)) ? i_wb_data[NUM_BUTTONS-1:0] : '0;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_stable    <= '0;
      r_btn_event <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1     <= buttons;
      r_sync2     <= r_sync1;
      r_stable    <= w_stable_nxt;
      r_btn_event <= (r_btn_event & ~w_evt_clr) | w_evt_set;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if ((r_sync2[i] == r_stable[i]) || w_cnt_hit[i]) r_cnt[i] <= '0;
        else                                             r_cnt[i] <= r_cnt[i] + CNT_ONE;
      end
    end
  end

  assign w_pwm = (r_pwm_cnt < r_pwm_duty);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pwm_cnt <= '0;
      r_leds    <= '0;
      r_led_enb <= '1;
      r_irq     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      r_leds    <= r_led_val & (~r_led_mode | {NUM_LEDS{w_pwm}});
      r_led_enb <= r_led_oeb;
      r_irq     <= |(r_btn_event & r_irq_en);
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_data = r_rdata;
  assign leds      = r_leds;
  assign led_enb   = r_led_enb;
  assign irq       = r_irq;

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Bench for wb_io_ctrl: bus reads are scored against a register-map model
// through an expected queue; LEDs, PWM duty, debounce and irq are checked directly.
module tb_wb_io_ctrl;

  localparam int          NB   = 3;
  localparam int          NL   = 4;
  localparam int          DW   = 16;
  localparam int          PW   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          cyc     = 1'b0;
  logic          stb     = 1'b0;
  logic          we      = 1'b0;
  logic [31:0]   addr    = '0;
  logic [31:0]   wdata   = '0;
  logic          ack;
  logic [31:0]   rdata;
  logic [NB-1:0] buttons = '0;
  logic [NL-1:0] leds;
  logic [NL-1:0] led_enb;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  logic [NL-1:0] m_led_val, m_led_mode, m_led_oeb;
  logic [PW-1:0] m_duty;
  logic [NB-1:0] m_btn_state, m_btn_event, m_irq_en;
  logic [DW-1:0] m_debounce;

  wb_io_ctrl #(
    .NUM_BUTTONS(NB), .NUM_LEDS(NL), .DEBOUNCE_W(DW), .PWM_W(PW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(ack), .o_wb_data(rdata),
    .buttons(buttons), .leds(leds), .led_enb(led_enb), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // register-map reference model
  task automatic model_reset();
    m_led_val = '0; m_led_mode = '0; m_duty = '0; m_btn_state = '0;
    m_btn_event = '0; m_irq_en = '0; m_debounce = '1; m_led_oeb = '1;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      8'h00: r[NL-1:0] = m_led_val;
      8'h04: r[NL-1:0] = m_led_mode;
      8'h08: r[PW-1:0] = m_duty;
      8'h0C: r[NB-1:0] = m_btn_state;
      8'h10: r[NB-1:0] = m_btn_event;
      8'h14: r[NB-1:0] = m_irq_en;
      8'h18: r[DW-1:0] = m_debounce;
      8'h1C: r[NL-1:0] = m_led_oeb;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d);
    case (off)
      8'h00: m_led_val   = d[NL-1:0];
      8'h04: m_led_mode  = d[NL-1:0];
      8'h08: m_duty      = d[PW-1:0];
      8'h10: m_btn_event = m_btn_event & ~d[NB-1:0];
      8'h14: m_irq_en    = d[NB-1:0];
      8'h18: m_debounce  = d[DW-1:0];
      8'h1C: m_led_oeb   = d[NL-1:0];
      default: ;
    endcase
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input bit expect_ack, input string name);
    int waited;
    bit got;
    waited = 0;
    got = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    if (expect_ack) begin
      exp_q.push_back({~w, (w ? 32'h0 : model_read(a[7:0]))});
      if (w) model_write(a[7:0], d);
    end
    while (!got && waited < 6) begin
      @(posedge clk); #1;
      waited++;
      if (ack) got = 1'b1;
    end
    checks++;
    if (expect_ack && (!got || waited != 1)) begin
      errors++;
      $display("FAIL %s ack: got ack=%0b after %0d cycles, expected ack after 1 cycle", name, got, waited);
      if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
    end else if (!expect_ack && got) begin
      errors++;
      $display("FAIL %s ack: got ack=1, expected no ack", name);
    end
    if (got) begin
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
    wb_access(BASE | {24'h0, off}, 1'b1, d, 1'b1, "write");
  endtask

  task automatic wb_read(input logic [7:0] off);
    wb_access(BASE | {24'h0, off}, 1'b0, 32'h0, 1'b1, "read");
  endtask

  // scoreboard monitor
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (ack) begin
      check("ack_single_cycle", {31'h0, prev_ack}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_ack: got ack=1 with data 0x%0h, expected no ack", rdata);
      end else begin
        e = exp_q.pop_front();
        if (e[32]) check("read_data", rdata, e[31:0]);
      end
    end else begin
      check("idle_data", rdata, 32'h0);
    end
    prev_ack = ack;
  end

  initial begin
    int cnt;
    int b;
    int len;
    int d;
    logic [PW-1:0] duties [4];

    model_reset();

    // reset state
    #3 reset_n = 1'b0;
    cycles(3);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_data", rdata, 32'h0);
    check("rst_leds", {28'h0, leds}, 32'h0);
    check("rst_led_enb", {28'h0, led_enb}, 32'hF);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    cycles(4);
    wb_read(8'h18);
    wb_read(8'h1C);
    wb_read(8'h00);

    // basic LED write / read-back
    wb_write(8'h00, 32'h5);
    wb_write(8'h1C, 32'h0);
    wb_read(8'h00);
    cycles(2);
    check("leds_basic", {28'h0, leds}, 32'h5);
    check("led_enb_basic", {28'h0, led_enb}, 32'h0);

    // randomized register traffic
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [7:0] off;
      k = $urandom_range(0, 9);
      if (k < 8)       off = 8'(k * 4);
      else if (k == 8) off = 8'(32 + 4 * $urandom_range(0, 55));
      else             off = 8'h0C;
      if ($urandom_range(0, 1) == 1) wb_write(off, $urandom);
      else                           wb_read(off);
    end
    wb_write(8'h04, 32'h0);
    for (int o = 0; o < 8; o++) wb_read(8'(o * 4));
    cycles(3);
    check("leds_static", {28'h0, leds}, {28'h0, m_led_val});
    check("led_enb_static", {28'h0, led_enb}, {28'h0, m_led_oeb});
    check("irq_idle", {31'h0, irq}, 32'h0);

    // PWM duty over one full period
    wb_write(8'h00, 32'h1);
    wb_write(8'h04, 32'h1);
    duties[0] = 8'd64; duties[1] = 8'd0; duties[2] = 8'hFF; duties[3] = 8'($urandom_range(1, 254));
    for (int t = 0; t < 4; t++) begin
      wb_write(8'h08, {24'h0, duties[t]});
      cycles(3);
      cnt = 0;
      repeat (256) begin
        @(negedge clk);
        if (leds[0]) cnt++;
      end
      check("pwm_high_cycles", cnt, {24'h0, duties[t]});
      check("pwm_other_leds", {29'h0, leds[3:1]}, 32'h0);
    end
    wb_read(8'h08);

    // debounce: short glitch filtered, long press accepted
    wb_write(8'h14, 32'h0);
    wb_write(8'h18, 32'd4);
    buttons[0] = 1'b1;
    cycles(3);
    buttons[0] = 1'b0;
    cycles(10);
    wb_read(8'h0C);
    wb_read(8'h10);
    buttons[0] = 1'b1;
    cycles(12);
    m_btn_state[0] = 1'b1;
    m_btn_event[0] = 1'b1;
    wb_read(8'h0C);
    wb_read(8'h10);
    check("irq_masked", {31'h0, irq}, 32'h0);
    buttons[0] = 1'b0;
    cycles(12);
    m_btn_state[0] = 1'b0;
    wb_read(8'h0C);
    wb_read(8'h10);
    wb_write(8'h10, 32'h7);

    // random pulses: an event appears only for pulses longer than DEBOUNCE cycles
    for (int t = 0; t < 8; t++) begin
      d   = $urandom_range(0, 6);
      b   = $urandom_range(0, NB - 1);
      len = $urandom_range(1, 10);
      wb_write(8'h18, d);
      buttons[b] = 1'b1;
      cycles(len);
      buttons[b] = 1'b0;
      cycles(15);
      if (len >= d + 1) m_btn_event[b] = 1'b1;
      wb_read(8'h10);
      wb_read(8'h0C);
      wb_write(8'h10, 32'h7);
    end

    // interrupt and set-over-clear priority
    wb_write(8'h18, 32'd4);
    wb_write(8'h14, 32'h1);
    buttons[0] = 1'b1;
    cycles(12);
    m_btn_event[0] = 1'b1;
    check("irq_set", {31'h0, irq}, 32'h1);
    wb_write(8'h10, 32'h1);
    cycles(2);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    buttons[0] = 1'b0;
    cycles(12);
    buttons[0] = 1'b1;
    repeat (5) @(posedge clk);
    wb_write(8'h10, 32'h1);
    m_btn_event[0] = 1'b1;
    cycles(2);
    check("irq_set_priority", {31'h0, irq}, 32'h1);
    wb_read(8'h10);
    buttons[0] = 1'b0;
    cycles(12);

    // address decode and ignored writes
    wb_access(32'h3000_0100, 1'b0, 32'h0, 1'b0, "out_of_range");
    wb_read(8'h20);
    wb_write(8'h20, $urandom);
    wb_read(8'h20);
    wb_write(8'h0C, 32'h7);
    wb_read(8'h0C);

    // reset in the middle of an access and a debounce
    wb_write(8'h04, 32'h0);
    wb_write(8'h00, 32'h5);
    wb_write(8'h1C, 32'h0);
    wb_write(8'h14, 32'h7);
    cycles(3);
    check("pre_rst_leds", {28'h0, leds}, 32'h5);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    buttons[2] = 1'b1;
    cycles(2);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE;
    @(posedge clk); #2;
    check("pre_rst_ack", {31'h0, ack}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'h0, ack}, 32'h0);
    check("mid_rst_data", rdata, 32'h0);
    check("mid_rst_leds", {28'h0, leds}, 32'h0);
    check("mid_rst_led_enb", {28'h0, led_enb}, 32'hF);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0; buttons = '0;
    cycles(3);
    reset_n = 1'b1;
    model_reset();
    cycles(8);
    wb_read(8'h18);
    wb_read(8'h0C);
    wb_read(8'h10);
    wb_read(8'h00);
    check("post_rst_led_enb", {28'h0, led_enb}, 32'hF);

    cycles(4);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_io_ctrl.md
WB_IO_CTRL -- requirements
Module: wb_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 3, number of button inputs.
REQ-002 SHALL have parameter NUM_LEDS, default 4, number of LED outputs.
REQ-003 SHALL have parameter DEBOUNCE_W, default 16, width of the debounce counter and threshold.
REQ-004 SHALL have parameter PWM_W, default 8, width of the PWM counter and duty.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h3000_0000, register block base address.
REQ-006 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-008 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone cycle, strobe and write enable.
REQ-009 SHALL have ports i_wb_addr, i_wb_data  input  32 each  Wishbone byte address and write data.
REQ-010 SHALL have ports o_wb_ack  output  1 and o_wb_data  output  32  Wishbone acknowledge and read data.
REQ-011 SHALL have port buttons  input  NUM_BUTTONS  raw asynchronous button levels.
REQ-012 SHALL have port leds  output  NUM_LEDS  LED drive.
REQ-013 SHALL have port led_enb  output  NUM_LEDS  pad output-enable, active-low.
REQ-014 SHALL have port irq  output  1  level interrupt.

Function
REQ-015 SHALL select on i_wb_addr[31:8]==BASE_ADDR[31:8]; non-matching accesses receive no ack.
REQ-016 SHALL assert o_wb_ack for exactly one cycle, the cycle after a selected cyc&stb with ack low; ack is never high two consecutive cycles.
REQ-017 SHALL present read data on o_wb_data in the ack cycle; o_wb_data is 0 outside ack cycles.
REQ-018 SHALL map word offsets: 0x00 LED_VAL rw, 0x04 LED_MODE rw (1=PWM), 0x08 PWM_DUTY rw, 0x0C BTN_STATE ro, 0x10 BTN_EVENT rw1c, 0x14 IRQ_EN rw, 0x18 DEBOUNCE rw, 0x1C LED_OEB rw; registers right-aligned, unused bits read 0.
REQ-019 SHALL ack unmapped offsets, return 0, ignore writes; writes to BTN_STATE ignored.
REQ-020 SHALL take register writes effect in the ack cycle's clock edge.
REQ-021 SHALL synchronise each button through two flops before debounce.
REQ-022 SHALL per button: synced==stable clears counter; otherwise counter increments and, when counter==DEBOUNCE, stable takes synced and counter clears.
REQ-023 SHALL with DEBOUNCE=0 update stable the first cycle synced differs (no filtering).
REQ-024 SHALL set BTN_EVENT[i] on each stable 0->1 transition; bit sticky until written 1.
REQ-025 SHALL give set priority when a set and a write-1-clear hit the same bit in the same cycle.
REQ-026 SHALL run a free PWM_W-bit counter, wrapping from all-ones to 0; pwm = counter < PWM_DUTY.
REQ-027 SHALL drive leds[i] = LED_VAL[i] & (LED_MODE[i] ? pwm : 1), registered (one cycle after counter).
REQ-028 SHALL yield duty 0 -> LED always off; duty all-ones -> off one cycle per 2^PWM_W period.
REQ-029 SHALL drive led_enb = LED_OEB and irq = |(BTN_EVENT & IRQ_EN), both registered.

Reset
REQ-030 SHALL on reset_n low asynchronously clear: ack, o_wb_data, LED_VAL, LED_MODE, PWM_DUTY, BTN_EVENT, IRQ_EN, synchronisers, stable, counters, leds, irq.
REQ-031 SHALL reset DEBOUNCE to all-ones and LED_OEB/led_enb to all-ones (pads disabled).
REQ-032 SHALL abort any in-flight Wishbone access on reset (no ack after release for it); release is synchronous to clk.

Verification
REQ-033 SHALL cover: write 0x5 to 0x00, 0x0 to 0x1C, read 0x00 -> ack one cycle later, data 0x5, leds=0101, led_enb=0000.
REQ-034 SHALL cover: DEBOUNCE=4, button[0] high 3 cycles then low -> BTN_STATE stays 0; held 10 cycles -> BTN_STATE[0]=1, BTN_EVENT[0]=1.
REQ-035 SHALL cover: IRQ_EN=1, event on button 0 -> irq=1; write 1 to 0x10 -> irq=0; clear coincident with new edge -> bit stays 1.
REQ-036 SHALL cover: LED_VAL=1, LED_MODE=1, PWM_DUTY=64 (PWM_W=8) -> leds[0] high 64 of every 256 cycles; duty 0 -> always low.
REQ-037 SHALL cover: access to 0x3000_0100 -> no ack; offset 0x20 -> ack, data 0.
REQ-038 SHALL cover: reset_n low mid-access and mid-debounce -> all outputs at reset values same cycle, led_enb all-ones, no stray ack.
